addsub_mc: RTL and testbench

Parametrised multi-cycle integer adder/subtractor with a four-phase REQ/ACK handshake. It serves the FPU mantissa datapath and generalises the fixed 24-bit single-cycle adder. Operand width is a parameter. Carry propagates through CHUNK-bit slices, one slice per cycle, which trades latency for a short carry chain. Subtraction and a signed-overflow flag are supported.

---
 rtl/addsub_mc.sv | 129 ++++++++++++
 tb/tb_addsub_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_mc.sv
// Multi-cycle WIDTH-bit adder/subtractor: carry ripples through one CHUNK-bit slice per clock,
// four-phase REQ/ACK handshake. Define ADDSUB_SUB_EN to honour OP (subtraction); otherwise it always adds.
module addsub_mc #(
    parameter int WIDTH = 25,
    parameter int CHUNK = 5
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Z,
    output logic             COUT,
    output logic             OVF,
    output logic             ACK,
    output logic             BUSY
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_aq;
    logic [WIDTH-1:0] r_bq;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             r_ack;
    logic             r_busy;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_msb_cin;

    // Operands shift right one slice per cycle, so the active slice is always the low CHUNK bits.
    assign w_sum     = {1'b0, r_aq[CHUNK-1:0]} + {1'b0, r_bq[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_cnt == CW'(NCH - 1));
    // Carry into the slice MSB recovered from its sum bit: c_in = a ^ b ^ s.
    assign w_msb_cin = r_aq[CHUNK-1] ^ r_bq[CHUNK-1] ^ w_sum[CHUNK-1];

`ifndef ADDSUB_SUB_EN
    logic w_unused_op;
    assign w_unused_op = OP;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTN) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (REQ)    w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_HOLD;
            S_HOLD:  if (!REQ)   w_state_next = S_DONE;
            S_DONE:              w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_aq    <= '0;
            r_bq    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_aq    <= A;
`ifdef ADDSUB_SUB_EN
                        r_bq    <= OP ? ~B : B;
                        r_carry <= OP;
`else
                        r_bq    <= B;
                        r_carry <= 1'b0;
`endif
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_aq    <= r_aq >> CHUNK;
                    r_bq    <= r_bq >> CHUNK;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_sum[CHUNK];
                        r_ovf  <= w_msb_cin ^ w_sum[CHUNK];
                        r_ack  <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!REQ) r_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Each result slice is its own register, written only on its own CALC cycle.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            logic [CHUNK-1:0] r_zs;
            always_ff @(posedge CLK) begin
                if (!RSTN)
                    r_zs <= '0;
                else if (r_state == S_CALC && r_cnt == CW'(gi))
                    r_zs <= w_sum[CHUNK-1:0];
            end
            assign Z[gi*CHUNK +: CHUNK] = r_zs;
        end
    endgenerate

    assign COUT = r_cout;
    assign OVF  = r_ovf;
    assign ACK  = r_ack;
    assign BUSY = r_busy;
endmodule

// File: tb/tb_addsub_mc.sv
// Self-checking bench for addsub_mc (defaults WIDTH=25, CHUNK=5); honours ADDSUB_SUB_EN like the RTL.
module tb_addsub_mc;
    localparam int W = 25;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         REQ;
    logic         OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Z;
    logic         COUT;
    logic         OVF;
    logic         ACK;
    logic         BUSY;

    int n_vec = 0;
    int n_err = 0;

    addsub_mc #(.WIDTH(25), .CHUNK(5)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .OP(OP), .A(A), .B(B),
        .Z(Z), .COUT(COUT), .OVF(OVF), .ACK(ACK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: integer arithmetic on the operand values, returns {ovf, cout, z}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        longint ua, ub, sa, sb, ures, sres;
        logic   sub, cout, ovf;
        logic [W-1:0] z;
`ifdef ADDSUB_SUB_EN
        sub = op;
`else
        sub = 1'b0;
`endif
        ua = longint'(a);
        ub = longint'(b);
        sa = (a[W-1]) ? ua - (longint'(1) << W) : ua;
        sb = (b[W-1]) ? ub - (longint'(1) << W) : ub;
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            cout = (ures >= (longint'(1) << W));
        end
        ovf = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
        z   = W'(ures & ((longint'(1) << W) - 1));
        return {ovf, cout, z};
    endfunction

    // Accepts one operation and waits for ACK; leaves REQ as it was at ACK.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input bit mutate, input bit drop);
        logic [W+1:0] exp;
        int lat, busy_cnt;
        exp = model(a, b, op);
        A = a; B = b; OP = op; REQ = 1'b1;
        tick();
        busy_cnt = (BUSY === 1'b1) ? 1 : 0;
        n_vec++;
        if (BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_busy: got %b expected 1", tag, BUSY);
        end
        lat = 0;
        while (ACK !== 1'b1 && lat < 20) begin
            if (mutate) begin
                A = W'($urandom); B = W'($urandom); OP = 1'($urandom);
            end
            if (drop) REQ = 1'b0;
            tick();
            lat++;
            if (BUSY === 1'b1 && ACK !== 1'b1) busy_cnt++;
        end
        n_vec++;
        if (lat != 5 || busy_cnt != 5 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL %s latency: got lat=%0d busy_cycles=%0d busy=%b expected lat=5 busy_cycles=5 busy=0",
                     tag, lat, busy_cnt, BUSY);
        end
        n_vec++;
        if (Z !== exp[W-1:0] || COUT !== exp[W] || OVF !== exp[W+1]) begin
            n_err++;
            $display("FAIL %s result: a=%h b=%h op=%b got z=%h cout=%b ovf=%b expected z=%h cout=%b ovf=%b",
                     tag, a, b, op, Z, COUT, OVF, exp[W-1:0], exp[W], exp[W+1]);
        end
    endtask

    // Drops REQ, checks ACK falls at the next edge, then steps through DONE.
    task automatic end_op(input string tag);
        REQ = 1'b0;
        tick();
        n_vec++;
        if (ACK !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack_fall: got %b expected 0", tag, ACK);
        end
        tick();
    endtask

    task automatic test_reset();
        RSTN = 1'b0; REQ = 1'b1; OP = 1'b0; A = W'($urandom); B = W'($urandom);
        tick();
        tick();
        n_vec++;
        if (Z !== '0 || COUT !== 1'b0 || OVF !== 1'b0 || ACK !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got z=%h cout=%b ovf=%b ack=%b busy=%b expected all 0",
                     Z, COUT, OVF, ACK, BUSY);
        end
        RSTN = 1'b1;
        run_op("reset_first_accept", 25'h0000123, 25'h0000456, 1'b0, 1'b0, 1'b0);
        end_op("reset_first_accept");
    endtask

    task automatic test_directed();
        run_op("add_ovf", 25'h0FFFFFF, 25'h0000001, 1'b0, 1'b0, 1'b0);
        end_op("add_ovf");
        run_op("add_wrap", 25'h1FFFFFF, 25'h0000001, 1'b0, 1'b0, 1'b0);
        end_op("add_wrap");
        run_op("sub_5_7", 25'd5, 25'd7, 1'b1, 1'b0, 1'b0);
        end_op("sub_5_7");
        run_op("sub_neg_ovf", 25'h1000000, 25'h0000001, 1'b1, 1'b0, 1'b0);
        end_op("sub_neg_ovf");
    endtask

    task automatic test_handshake();
        logic [W+1:0] exp;
        int bad;
        exp = model(25'h0ABCDEF, 25'h1234567, 1'b0);
        run_op("hold", 25'h0ABCDEF, 25'h1234567, 1'b0, 1'b0, 1'b0);
        bad = 0;
        A = W'($urandom); B = W'($urandom);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ACK !== 1'b1 || Z !== exp[W-1:0]) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_ack: got %0d bad cycles (ack=%b z=%h) expected 0", bad, ACK, Z);
        end
        REQ = 1'b0;
        tick();
        n_vec++;
        if (ACK !== 1'b0) begin
            n_err++;
            $display("FAIL hold_ack_fall: got %b expected 0", ACK);
        end
        REQ = 1'b1;
        tick();
        n_vec++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL done_ignores_req: got busy=%b expected 0", BUSY);
        end
        run_op("reaccept", 25'h0000010, 25'h0000020, 1'b1, 1'b0, 1'b0);
        end_op("reaccept");
        run_op("mutate_mid", 25'h1555555, 25'h0AAAAAA, 1'b1, 1'b1, 1'b0);
        end_op("mutate_mid");
    endtask

    task automatic test_req_drop();
        run_op("req_drop", 25'h0F0F0F0, 25'h00FF00F, 1'b0, 1'b0, 1'b1);
        tick();
        n_vec++;
        if (ACK !== 1'b0) begin
            n_err++;
            $display("FAIL req_drop_ack_pulse: got %b expected 0", ACK);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        A = 25'h1FFFFFF; B = 25'h1FFFFFF; OP = 1'b0; REQ = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        RSTN = 1'b0; REQ = 1'b0;
        tick();
        n_vec++;
        if (Z !== '0 || COUT !== 1'b0 || OVF !== 1'b0 || ACK !== 1'b0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_state: got z=%h cout=%b ovf=%b ack=%b busy=%b expected all 0",
                     Z, COUT, OVF, ACK, BUSY);
        end
        RSTN = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ACK === 1'b1 || BUSY === 1'b1) acks++;
        end
        n_vec++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL reset_mid_no_ack: got %0d active cycles expected 0", acks);
        end
        run_op("after_reset_3p4", 25'd3, 25'd4, 1'b0, 1'b0, 1'b0);
        end_op("after_reset_3p4");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end_op("random");
        end
    endtask

    initial begin
        RSTN = 1'b0; REQ = 1'b0; OP = 1'b0; A = '0; B = '0;
        test_reset();
        test_directed();
        test_handshake();
        test_req_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
